// File: rtl/uart_rx_frontend.sv
// 8N1 UART receive front-end: synchronizes rx, finds start bits, samples each bit
// at mid-period and hands completed bytes downstream over a valid/ready holding register.
`timescale 1ns/1ps
module uart_rx_frontend #(
    parameter int DefaultRate = 324,
    parameter int SyncStages  = 2
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        rx,
    input  logic [15:0] rate,
    output logic [7:0]  data,
    output logic        valid,
    input  logic        ready,
    output logic        framing_error,
    output logic        overrun,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t                state_reg;
    logic [SyncStages-1:0] sync_reg;
    logic                  rx_s;
    logic                  rx_prev_reg;
    logic                  rx_fall;
    logic [15:0]           rate_eff;
    logic [15:0]           rate_q_reg;
    logic [15:0]           count_reg;
    logic [2:0]            bit_idx_reg;
    logic [7:0]            shift_reg;
    logic [7:0]            data_reg;
    logic                  valid_reg;
    logic                  framing_error_reg;
    logic                  overrun_reg;
    logic                  busy_reg;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sync_reg <= {SyncStages{1'b1}};
        end else begin
            sync_reg <= {sync_reg[SyncStages-2:0], rx};
        end
    end

    assign rx_s    = sync_reg[SyncStages-1];
    assign rx_fall = rx_prev_reg & ~rx_s;

    // A rate of 1 cannot place a mid-bit sample, so it is promoted to 2.
    always_comb begin
        rate_eff = rate;
        if (rate == 16'd0) begin
            rate_eff = 16'(DefaultRate);
        end else if (rate == 16'd1) begin
            rate_eff = 16'd2;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_reg         <= IDLE;
            rx_prev_reg       <= 1'b1;
            rate_q_reg        <= 16'd0;
            count_reg         <= 16'd0;
            bit_idx_reg       <= 3'd0;
            shift_reg         <= 8'd0;
            data_reg          <= 8'd0;
            valid_reg         <= 1'b0;
            framing_error_reg <= 1'b0;
            overrun_reg       <= 1'b0;
            busy_reg          <= 1'b0;
        end else begin
            rx_prev_reg       <= rx_s;
            framing_error_reg <= 1'b0;
            overrun_reg       <= 1'b0;
            if (valid_reg && ready) begin
                valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (rx_fall) begin
                        rate_q_reg <= rate_eff;
                        count_reg  <= (rate_eff >> 1) - 16'd1;
                        state_reg  <= START;
                        busy_reg   <= 1'b1;
                    end
                end
                START: begin
                    if (count_reg == 16'd0) begin
                        if (!rx_s) begin
                            count_reg   <= rate_q_reg - 16'd1;
                            bit_idx_reg <= 3'd0;
                            state_reg   <= DATA;
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end else begin
                        count_reg <= count_reg - 16'd1;
                    end
                end
                DATA: begin
                    if (count_reg == 16'd0) begin
                        shift_reg[bit_idx_reg] <= rx_s;
                        count_reg              <= rate_q_reg - 16'd1;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end else begin
                        count_reg <= count_reg - 16'd1;
                    end
                end
                STOP: begin
                    if (count_reg == 16'd0) begin
                        if (rx_s) begin
                            // Load only if the holding register is free or being drained now.
                            if (!valid_reg || ready) begin
                                data_reg  <= shift_reg;
                                valid_reg <= 1'b1;
                            end else begin
                                overrun_reg <= 1'b1;
                            end
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            framing_error_reg <= 1'b1;
                            state_reg         <= BREAK;
                        end
                    end else begin
                        count_reg <= count_reg - 16'd1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign data          = data_reg;
    assign valid         = valid_reg;
    assign framing_error = framing_error_reg;
    assign overrun       = overrun_reg;
    assign busy          = busy_reg;

endmodule
